// File: rtl/rv32i_trap_sequencer.sv
// rv32i_trap_sequencer: moves the core into and out of one interrupt handler at a time
module rv32i_trap_sequencer #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] VECTOR_BASE = 32'h0000_0100,
    parameter int COUNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               irq_pending_i,
    input  logic [XLEN-1:0]    irq_offset_i,
    output logic               irq_advance_o,
    output logic               irq_clear_o,
    input  logic               gie_i,
    input  logic               instr_boundary_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic               mret_i,
    output logic               pc_load_o,
    output logic [XLEN-1:0]    pc_load_value_o,
    output logic               stall_o,
    output logic [XLEN-1:0]    epc_o,
    output logic               in_handler_o,
    output logic               spurious_mret_o,
    output logic [COUNT_W-1:0] irq_count_o
);
    typedef enum logic [1:0] {IDLE, TAKE, HANDLER, RETURN} state_t;
    state_t state;
    logic trigger;
    assign trigger = irq_pending_i & gie_i & instr_boundary_i;
    // State, return PC, counter, sticky flag and the Moore flags of the next state update together
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            epc_o           <= '0;
            irq_count_o     <= '0;
            spurious_mret_o <= 1'b0;
            irq_advance_o   <= 1'b0;
            irq_clear_o     <= 1'b0;
            pc_load_o       <= 1'b0;
            stall_o         <= 1'b0;
            in_handler_o    <= 1'b0;
        end else begin
            spurious_mret_o <= spurious_mret_o | (mret_i & (state != HANDLER));
            irq_advance_o   <= 1'b0;
            irq_clear_o     <= 1'b0;
            pc_load_o       <= 1'b0;
            stall_o         <= 1'b0;
            in_handler_o    <= 1'b0;
            case (state)
                IDLE: if (trigger) begin
                    state         <= TAKE;
                    epc_o         <= pc_i;
                    irq_count_o   <= &irq_count_o ? irq_count_o : irq_count_o + COUNT_W'(1);
                    irq_advance_o <= 1'b1;
                    pc_load_o     <= 1'b1;
                    stall_o       <= 1'b1;
                end
                TAKE: begin
                    state        <= HANDLER;
                    in_handler_o <= 1'b1;
                end
                HANDLER: if (mret_i) begin
                    state       <= RETURN;
                    irq_clear_o <= 1'b1;
                    pc_load_o   <= 1'b1;
                    stall_o     <= 1'b1;
                end else begin
                    in_handler_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Vector offset is only guaranteed during TAKE, so the target is formed combinationally
    always_comb begin
        pc_load_value_o = state == TAKE ? VECTOR_BASE + irq_offset_i : state == RETURN ? epc_o : '0;
    end
endmodule

// File: tb/tb_rv32i_trap_sequencer.sv
// tb_rv32i_trap_sequencer: scoreboard bench with directed scenarios and random traffic
module tb_rv32i_trap_sequencer;
    localparam int CW = 2;
    localparam logic [31:0] VB = 32'h0000_0100;
    logic clk = 0, rst = 1, pend = 0, gie = 0, bnd = 0, mret = 0;
    logic [31:0] off = 0, pc = 0;
    logic adv, clr, load, stall, inh, spur;
    logic [31:0] lval, epc;
    logic [CW-1:0] cnt;
    int checks = 0, failures = 0;
    typedef struct {bit entry; logic [31:0] val;} ev_t;
    ev_t q[$];
    bit m_inh = 0, m_gap = 0, m_spur = 0;
    int m_cnt = 0;
    logic [31:0] m_epc = 0;

    rv32i_trap_sequencer #(.XLEN(32), .VECTOR_BASE(VB), .COUNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .irq_pending_i(pend), .irq_offset_i(off),
        .irq_advance_o(adv), .irq_clear_o(clr), .gie_i(gie), .instr_boundary_i(bnd),
        .pc_i(pc), .mret_i(mret), .pc_load_o(load), .pc_load_value_o(lval),
        .stall_o(stall), .epc_o(epc), .in_handler_o(inh), .spurious_mret_o(spur),
        .irq_count_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // The controller drops pending once it sees the advance pulse
    task automatic step();
        @(posedge clk);
        #1;
        if (adv) pend = 0;
    endtask

    // Reference: handler open/closed plus a one-cycle transition gap after each entry or return
    always @(posedge clk) begin
        if (rst) begin
            m_inh = 0; m_gap = 0; m_spur = 0; m_cnt = 0; m_epc = 0;
            q.delete();
        end else if (m_gap) begin
            if (mret) m_spur = 1;
            m_gap = 0;
        end else if (m_inh) begin
            if (mret) begin
                m_inh = 0; m_gap = 1;
                q.push_back('{1'b0, m_epc});
            end
        end else begin
            if (mret) m_spur = 1;
            if (pend && gie && bnd) begin
                m_epc = pc;
                m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
                m_inh = 1; m_gap = 1;
                q.push_back('{1'b1, VB + off});
            end
        end
    end

    // Monitor: every redirect must match the oldest expected event
    always @(negedge clk) begin
        ev_t e;
        chk("in_handler", {31'b0, inh}, {31'b0, m_inh && !m_gap});
        chk("spurious", {31'b0, spur}, {31'b0, m_spur});
        chk("count", 32'(cnt), m_cnt);
        chk("epc", epc, m_epc);
        if (load) begin
            if (q.size() == 0) chk("unexpected_load", 1, 0);
            else begin
                e = q.pop_front();
                chk("load_value", lval, e.val);
                chk("advance", {31'b0, adv}, {31'b0, e.entry});
                chk("clear", {31'b0, clr}, {31'b0, !e.entry});
                chk("stall", {31'b0, stall}, 1);
            end
        end else begin
            chk("idle_pulses", {29'b0, adv, clr, stall}, 0);
            chk("idle_value", lval, 0);
        end
        if (q.size() != 0) chk("missing_load", 0, 1);
    end

    task automatic enter_exit(input logic [31:0] p, input logic [31:0] o);
        gie = 1; bnd = 1; pc = p; off = o; pend = 1;
        step();
        step();
        mret = 1;
        step();
        mret = 0;
        step();
    endtask

    initial begin
        step();
        rst = 0;
        chk("reset_load", {31'b0, load}, 0);
        chk("reset_epc", epc, 0);
        // take and return
        gie = 1; bnd = 1; pc = 32'h2000; off = 32'h8; pend = 1;
        step();
        chk("take_load", {31'b0, load}, 1);
        chk("take_value", lval, 32'h108);
        chk("take_adv", {31'b0, adv}, 1);
        chk("take_stall", {31'b0, stall}, 1);
        step();
        chk("handler", {31'b0, inh}, 1);
        chk("handler_epc", epc, 32'h2000);
        mret = 1;
        step();
        mret = 0;
        chk("ret_load", {31'b0, load}, 1);
        chk("ret_value", lval, 32'h2000);
        chk("ret_clear", {31'b0, clr}, 1);
        step();
        chk("ret_idle", {30'b0, inh, load}, 0);
        // gating by gie
        gie = 0; pend = 1; off = 32'h20; pc = 32'h3000;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("gated", {31'b0, load}, 0);
        end
        gie = 1;
        step();
        chk("gate_open", {31'b0, load}, 1);
        chk("gate_value", lval, 32'h120);
        step();
        mret = 1;
        step();
        mret = 0;
        step();
        // boundary wait
        bnd = 0; pend = 1; off = 32'h4;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("no_boundary", {30'b0, inh, load}, 0);
        end
        bnd = 1; pc = 32'h40;
        step();
        step();
        chk("boundary_epc", epc, 32'h40);
        // nested pending ignored, mret wins over pending
        pend = 1; off = 32'hC; pc = 32'h5000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nested_ignored", {30'b0, inh, load}, 2);
        end
        mret = 1;
        step();
        mret = 0;
        chk("mret_wins", {31'b0, clr}, 1);
        chk("mret_wins_count", 32'(cnt), 3);
        step();
        step();
        chk("reentry_adv_epc", epc, 32'h5000);
        step();
        mret = 1;
        step();
        mret = 0;
        step();
        // spurious mret
        pend = 0;
        mret = 1;
        step();
        mret = 0;
        chk("spurious_set", {31'b0, spur}, 1);
        chk("spurious_noload", {31'b0, load}, 0);
        step();
        chk("spurious_sticky", {31'b0, spur}, 1);
        rst = 1;
        step();
        rst = 0;
        chk("spurious_reset", {31'b0, spur}, 0);
        // saturating counter
        for (int i = 0; i < 5; i++) enter_exit(32'h100 * i, 32'h10 * i);
        chk("count_sat", 32'(cnt), 3);
        // reset mid-handler
        gie = 1; bnd = 1; pend = 1; off = 32'h30; pc = 32'h7000;
        step();
        step();
        chk("pre_reset_handler", {31'b0, inh}, 1);
        rst = 1;
        step();
        rst = 0;
        chk("reset_outputs", {26'b0, adv, clr, load, stall, inh, spur}, 0);
        chk("reset_state_vals", epc | 32'(cnt) | lval, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            mret = inh ? ($urandom_range(5) == 0) : ($urandom_range(40) == 0);
            gie = $urandom_range(7) != 0;
            bnd = $urandom_range(2) != 0;
            pc = $urandom;
            if (!pend && !adv && $urandom_range(3) == 0) begin
                pend = 1;
                off = $urandom;
            end
            rst = $urandom_range(150) == 0;
            if (rst) pend = 0;
            step();
        end
        mret = 0; rst = 0; pend = 0;
        repeat (4) step();
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
